nms_score_loader: RTL and testbench

NMS_SCORE_LOADER -- requirements
Module: nms_score_loader

---
 rtl/nms_score_loader.sv | 121 ++++++++++++
 tb/tb_nms_score_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nms_score_loader.sv
// Loads the 3x3 score window around (cx, cy) into a 9-entry register file.
// Out-of-image neighbours are zero-filled without touching memory.
module nms_score_loader #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        cx,
  input  logic [7:0]        cy,
  input  logic              consume,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [11:0]       memRdData,
  output logic [3:0]        regAddr,
  output logic [11:0]       scoreData,
  output logic              readEn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, LAST, VALID} state_t;

  localparam logic signed [9:0] W_S = 10'(IMG_W);
  localparam logic signed [9:0] H_S = 10'(IMG_H);

  state_t            state, state_nxt;
  logic [3:0]        slot;
  logic [7:0]        cx_q, cy_q;
  logic signed [9:0] dx, dy, col, row;
  logic              in_img, coord_ok, accept;
  logic [ADDR_W-1:0] addr;
  logic              wr_vld, wr_rd;
  logic [3:0]        wr_slot;

  assign coord_ok = ({2'b00, cx} < 10'(IMG_W)) && ({2'b00, cy} < 10'(IMG_H));
  assign accept   = (state == IDLE) && start && coord_ok;

  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   if (slot == 4'd8) state_nxt = LAST;
      LAST:    state_nxt = VALID;
      VALID:   if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // slot -> (dx, dy): centre first, then raster order of the 8 neighbours
  always_comb begin
    dx = '0;
    dy = '0;
    case (slot)
      4'd1: begin dx = -10'sd1; dy = -10'sd1; end
      4'd2: begin dx =  10'sd0; dy = -10'sd1; end
      4'd3: begin dx =  10'sd1; dy = -10'sd1; end
      4'd4: begin dx = -10'sd1; dy =  10'sd0; end
      4'd5: begin dx =  10'sd1; dy =  10'sd0; end
      4'd6: begin dx = -10'sd1; dy =  10'sd1; end
      4'd7: begin dx =  10'sd0; dy =  10'sd1; end
      4'd8: begin dx =  10'sd1; dy =  10'sd1; end
      default: ;
    endcase
  end

  assign col    = $signed({2'b00, cx_q}) + dx;
  assign row    = $signed({2'b00, cy_q}) + dy;
  assign in_img = (col >= 10'sd0) && (col < W_S) && (row >= 10'sd0) && (row < H_S);
  assign addr   = ADDR_W'($unsigned(row)) * ADDR_W'(IMG_W) + ADDR_W'($unsigned(col));

  always_comb begin
    memRdEn = (state == FETCH) && in_img;
    memAddr = memRdEn ? addr : '0;
    readEn  = (state == VALID);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      slot <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      slot <= (state == FETCH) ? slot + 4'd1 : 4'd0;
      if (accept) begin
        cx_q <= cx;
        cy_q <= cy;
      end
    end
  end

  // Write stage trails the issue stage by one cycle to line up with read data
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_vld  <= 1'b0;
      wr_rd   <= 1'b0;
      wr_slot <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_vld  <= (state == FETCH);
      wr_rd   <= memRdEn;
      wr_slot <= slot;
      done    <= (state == LAST);
      err     <= (state == IDLE) && start && !coord_ok;
    end
  end

  assign regAddr   = wr_vld ? wr_slot : 4'hF;
  assign scoreData = (wr_vld && wr_rd) ? memRdData : 12'h000;

endmodule

// File: tb/tb_nms_score_loader.sv
// Directed bench for nms_score_loader; memory model returns address[11:0].
module tb_nms_score_loader;

  logic        clk = 1'b0;
  logic        RESET, start, consume;
  logic [7:0]  cx, cy;
  logic        memRdEn;
  logic [14:0] memAddr;
  logic [11:0] memRdData;
  logic [3:0]  regAddr;
  logic [11:0] scoreData;
  logic        readEn, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  nms_score_loader #(.IMG_W(160), .IMG_H(120), .ADDR_W(15)) dut (
    .clk(clk), .RESET(RESET), .start(start), .cx(cx), .cy(cy),
    .consume(consume), .memRdEn(memRdEn), .memAddr(memAddr),
    .memRdData(memRdData), .regAddr(regAddr), .scoreData(scoreData),
    .readEn(readEn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // garbage on idle cycles so zero-forcing of skipped slots is visible
  always @(posedge clk) memRdData <= memRdEn ? memAddr[11:0] : 12'hABC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_memRdEn"}, 32'(memRdEn), 0);
    check({tag, "_memAddr"}, 32'(memAddr), 0);
    check({tag, "_regAddr"}, 32'(regAddr), 32'hF);
    check({tag, "_scoreData"}, 32'(scoreData), 0);
    check({tag, "_readEn"}, 32'(readEn), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Starts a load in the current cycle (cycle 0) and checks cycles 1..11.
  task automatic run_load(input logic [7:0] x, input logic [7:0] y,
                          input logic [8:0][14:0] a, input logic [8:0] v);
    logic [11:0] ed;
    start = 1'b1; cx = x; cy = y;
    tick();
    start = 1'b0; cx = 8'd200; cy = 8'd3;   // must not disturb the latched centre
    for (int k = 0; k < 9; k++) begin
      check($sformatf("slot%0d_rden", k), 32'(memRdEn), 32'(v[k]));
      if (v[k]) check($sformatf("slot%0d_addr", k), 32'(memAddr), 32'(a[k]));
      check($sformatf("slot%0d_busy", k), 32'(busy), 1);
      check($sformatf("slot%0d_readEn", k), 32'(readEn), 0);
      if (k == 0) check("slot0_nowr", 32'(regAddr), 32'hF);
      else begin
        ed = v[k-1] ? a[k-1][11:0] : 12'h000;
        check($sformatf("wr%0d_addr", k-1), 32'(regAddr), 32'(k-1));
        check($sformatf("wr%0d_data", k-1), 32'(scoreData), 32'(ed));
      end
      tick();
    end
    ed = v[8] ? a[8][11:0] : 12'h000;
    check("wr8_addr", 32'(regAddr), 8);
    check("wr8_data", 32'(scoreData), 32'(ed));
    check("last_rden", 32'(memRdEn), 0);
    check("last_readEn", 32'(readEn), 0);
    tick();
    check("valid_readEn", 32'(readEn), 1);
    check("valid_done", 32'(done), 1);
    check("valid_busy", 32'(busy), 1);
    check("valid_regAddr", 32'(regAddr), 32'hF);
    check("valid_scoreData", 32'(scoreData), 0);
  endtask

  task automatic release_win();
    consume = 1'b1;
    tick();
    consume = 1'b0;
    check("rel_readEn", 32'(readEn), 0);
    check("rel_busy", 32'(busy), 0);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; consume = 1'b0; cx = '0; cy = '0;
    tick(); tick();
    RESET = 1'b0;
    check_idle("reset");

    // consume outside VALID is harmless
    consume = 1'b1; tick(); consume = 1'b0;
    check_idle("stray_consume");

    // interior window
    run_load(8'd10, 8'd5,
      {15'd971, 15'd970, 15'd969, 15'd811, 15'd809, 15'd651, 15'd650, 15'd649, 15'd810},
      9'h1FF);
    tick();
    check("done_pulse", 32'(done), 0);
    check("readEn_hold", 32'(readEn), 1);
    release_win();

    // top-left corner
    run_load(8'd0, 8'd0,
      {15'd161, 15'd160, 15'd0, 15'd1, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0},
      9'b110100001);
    release_win();

    // bottom-right corner
    run_load(8'd159, 8'd119,
      {15'd0, 15'd0, 15'd0, 15'd0, 15'd19198, 15'd0, 15'd19039, 15'd19038, 15'd19199},
      9'b000010111);
    release_win();

    // rejected starts
    start = 1'b1; cx = 8'd160; cy = 8'd0;
    tick();
    start = 1'b0;
    check("rej_x_err", 32'(err), 1);
    check("rej_x_busy", 32'(busy), 0);
    check("rej_x_regAddr", 32'(regAddr), 32'hF);
    check("rej_x_rden", 32'(memRdEn), 0);
    tick();
    check("rej_x_err_clr", 32'(err), 0);
    check("rej_x_busy2", 32'(busy), 0);
    start = 1'b1; cx = 8'd5; cy = 8'd120;
    tick();
    start = 1'b0;
    check("rej_y_err", 32'(err), 1);
    check("rej_y_busy", 32'(busy), 0);
    tick();
    check_idle("rej_y_after");

    // handshake: hold VALID, starts there are ignored
    run_load(8'd10, 8'd5,
      {15'd971, 15'd970, 15'd969, 15'd811, 15'd809, 15'd651, 15'd650, 15'd649, 15'd810},
      9'h1FF);
    for (int i = 0; i < 20; i++) begin
      start = 1'b1; cx = 8'd1; cy = 8'd1;
      tick();
      check($sformatf("hold%0d_readEn", i), 32'(readEn), 1);
      check($sformatf("hold%0d_rden", i), 32'(memRdEn), 0);
    end
    consume = 1'b1; start = 1'b1;
    tick();
    consume = 1'b0; start = 1'b0;
    check("hs_readEn_fall", 32'(readEn), 0);
    check("hs_busy_fall", 32'(busy), 0);
    run_load(8'd20, 8'd30,
      {15'd4981, 15'd4980, 15'd4979, 15'd4821, 15'd4819, 15'd4661, 15'd4660, 15'd4659, 15'd4820},
      9'h1FF);
    release_win();

    // reset in cycle 5 of a load
    start = 1'b1; cx = 8'd10; cy = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_rst_regAddr", 32'(regAddr), 3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_idle("mid_rst");
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("post_rst%0d_regAddr", i), 32'(regAddr), 32'hF);
      check($sformatf("post_rst%0d_busy", i), 32'(busy), 0);
    end
    run_load(8'd10, 8'd5,
      {15'd971, 15'd970, 15'd969, 15'd811, 15'd809, 15'd651, 15'd650, 15'd649, 15'd810},
      9'h1FF);
    release_win();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
